// File: rtl/ddmtd_pkg.sv
// -----------------------------------------------------------------------------
// ddmtd_pkg
//   Shared definitions for the DDMTD helper-clock loop: sequencer state codes,
//   default phase-error width and the default loop-filter gain shifts used by
//   both the lock sequencer and the loop filter instantiation.
// -----------------------------------------------------------------------------
package ddmtd_pkg;

    // Default phase-error width coming out of the DDMTD sampler (signed).
    localparam int ERR_W_DEF  = 18;
    localparam int SH_W_DEF   = 4;

    // Default loop-filter gain shifts: wide loop while acquiring, narrow
    // loop while tracking.
    localparam int KP_ACQ_DEF = 2;
    localparam int KI_ACQ_DEF = 8;
    localparam int KP_TRK_DEF = 4;
    localparam int KI_TRK_DEF = 10;

    // Sequencer states; the encoding is visible on state_o.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_ACQUIRE  = 3'd2,
        ST_TRACK    = 3'd3,
        ST_HOLDOVER = 3'd4
    } state_t;

    // The NCO follows the loop filter only while the loop is closed.
    function automatic logic loop_running(input state_t s);
        return (s == ST_ACQUIRE) || (s == ST_TRACK);
    endfunction

endpackage

// File: rtl/err_window_cmp.sv
// -----------------------------------------------------------------------------
// err_window_cmp
//   Combinational lock-window test on a signed phase error:
//   in_win = |phase_err| <= LOCK_THR.
//   The magnitude is formed one bit wider than the input so the most negative
//   code does not fold back onto itself; that code is always reported as out
//   of window regardless of the threshold.
//
// Ports:
//   phase_err  in  ERR_W  signed phase error
//   in_win     out 1      error magnitude is inside the lock window
// -----------------------------------------------------------------------------
module err_window_cmp #(
    parameter int ERR_W    = 18,
    parameter int LOCK_THR = 64
) (
    input  logic [ERR_W-1:0] phase_err,
    output logic             in_win
);

    localparam logic [ERR_W:0]   THR     = (ERR_W+1)'(LOCK_THR);
    localparam logic [ERR_W-1:0] MOST_NEG = {1'b1, {(ERR_W-1){1'b0}}};

    logic [ERR_W:0] err_ext;
    logic [ERR_W:0] err_abs;
    logic           is_most_neg;

    // NOTE: every signal written in always_comb is given a value on every
    // path (here, unconditionally) so no latch can be inferred.
    always_comb begin
        err_ext     = {phase_err[ERR_W-1], phase_err};
        err_abs     = phase_err[ERR_W-1] ? (~err_ext + 1'b1) : err_ext;
        is_most_neg = (phase_err == MOST_NEG);
        in_win      = !is_most_neg && (err_abs <= THR);
    end

endmodule

// File: rtl/ddmtd_lock_ctrl.sv
// -----------------------------------------------------------------------------
// ddmtd_lock_ctrl
//   Lock sequencer for the DDMTD helper-clock loop. Runs the loop through
//   CLEAR (integrator cleared, NCO held), ACQUIRE (wide gains) and TRACK
//   (narrow gains), and drops into HOLDOVER when beat samples stop arriving.
//   All outputs are registered and follow the state entered on the same edge.
//
// Ports:
//   clk          in  1      system clock
//   rst_n        in  1      asynchronous active-low reset
//   ena          in  1      global enable; 0 freezes everything (loss_pulse -> 0)
//   loop_en      in  1      closed-loop request; 0 forces IDLE
//   phase_valid  in  1      one-cycle strobe from the sampler
//   phase_err    in  ERR_W  signed phase error, qualified by phase_valid
//   lf_clear     out 1      synchronous clear of the loop-filter integrator
//   nco_hold     out 1      freeze NCO control input
//   kp_sh        out SH_W   proportional gain shift
//   ki_sh        out SH_W   integral gain shift
//   locked       out 1      lock indicator
//   loss_pulse   out 1      one-cycle pulse when lock is lost from TRACK
//   state_o      out 3      current state code
// -----------------------------------------------------------------------------
module ddmtd_lock_ctrl
    import ddmtd_pkg::*;
#(
    parameter int ERR_W      = ERR_W_DEF,
    parameter int SH_W       = SH_W_DEF,
    parameter int LOCK_THR   = 64,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4,
    parameter int CLEAR_CYC  = 4,
    parameter int WDOG_W     = 16,
    parameter int KP_ACQ     = KP_ACQ_DEF,
    parameter int KI_ACQ     = KI_ACQ_DEF,
    parameter int KP_TRK     = KP_TRK_DEF,
    parameter int KI_TRK     = KI_TRK_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             loop_en,
    input  logic             phase_valid,
    input  logic [ERR_W-1:0] phase_err,
    output logic             lf_clear,
    output logic             nco_hold,
    output logic [SH_W-1:0]  kp_sh,
    output logic [SH_W-1:0]  ki_sh,
    output logic             locked,
    output logic             loss_pulse,
    output logic [2:0]       state_o
);

    localparam int WIN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_CNT + 1);
    localparam int CLR_W  = $clog2(CLEAR_CYC + 1);

    // Each counter acts on the value it holds when the deciding event
    // arrives, so the "last" constant is one below the target count.
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(UNLOCK_CNT - 1);
    localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(CLEAR_CYC - 1);
    // Timeout fires on the idle cycle that would carry the watchdog to
    // 2^WDOG_W-1.
    localparam logic [WDOG_W-1:0] WDOG_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};

    localparam logic [SH_W-1:0] KP_ACQ_V = SH_W'(KP_ACQ);
    localparam logic [SH_W-1:0] KI_ACQ_V = SH_W'(KI_ACQ);
    localparam logic [SH_W-1:0] KP_TRK_V = SH_W'(KP_TRK);
    localparam logic [SH_W-1:0] KI_TRK_V = SH_W'(KI_TRK);

    state_t state, state_nxt;

    logic [WIN_W-1:0]  win_cnt,  win_nxt;
    logic [MISS_W-1:0] miss_cnt, miss_nxt;
    logic [CLR_W-1:0]  clr_cnt,  clr_nxt;
    logic [WDOG_W-1:0] wdog_cnt, wdog_nxt;

    logic             lf_clear_nxt;
    logic             nco_hold_nxt;
    logic [SH_W-1:0]  kp_nxt;
    logic [SH_W-1:0]  ki_nxt;
    logic             locked_nxt;
    logic             loss_nxt;

    logic in_win;

    err_window_cmp #(
        .ERR_W    (ERR_W),
        .LOCK_THR (LOCK_THR)
    ) u_win (
        .phase_err (phase_err),
        .in_win    (in_win)
    );

    // ---------------------------------------------------------------------
    // Next-state and counter logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        win_nxt   = win_cnt;
        miss_nxt  = miss_cnt;
        clr_nxt   = clr_cnt;
        wdog_nxt  = wdog_cnt;

        case (state)
            ST_IDLE: begin
                if (loop_en) state_nxt = ST_CLEAR;
            end

            // Samples are ignored here: only the dwell time matters.
            ST_CLEAR: begin
                if (clr_cnt == CLR_LAST) state_nxt = ST_ACQUIRE;
                else                     clr_nxt   = clr_cnt + 1'b1;
            end

            ST_ACQUIRE: begin
                if (phase_valid) begin
                    wdog_nxt = '0;
                    if (!in_win)                  win_nxt   = '0;
                    else if (win_cnt == WIN_LAST) state_nxt = ST_TRACK;
                    else                          win_nxt   = win_cnt + 1'b1;
                end else if (wdog_cnt == WDOG_LAST) begin
                    state_nxt = ST_HOLDOVER;
                end else begin
                    wdog_nxt = wdog_cnt + 1'b1;
                end
            end

            ST_TRACK: begin
                if (phase_valid) begin
                    wdog_nxt = '0;
                    if (in_win)                     miss_nxt  = '0;
                    else if (miss_cnt == MISS_LAST) state_nxt = ST_ACQUIRE;
                    else                            miss_nxt  = miss_cnt + 1'b1;
                end else if (wdog_cnt == WDOG_LAST) begin
                    state_nxt = ST_HOLDOVER;
                end else begin
                    wdog_nxt = wdog_cnt + 1'b1;
                end
            end

            // The sample that ends holdover restarts the loop; its error is
            // not window-tested.
            ST_HOLDOVER: begin
                if (phase_valid) state_nxt = ST_CLEAR;
            end

            default: state_nxt = ST_IDLE;
        endcase

        // Dropping the loop request overrides every other transition.
        if (!loop_en) state_nxt = ST_IDLE;

        // Every phase starts with fresh counters. Since each counter leaves
        // its state once it hits its last value, none can wrap.
        if (state_nxt != state) begin
            win_nxt  = '0;
            miss_nxt = '0;
            clr_nxt  = '0;
            wdog_nxt = '0;
        end
    end

    // ---------------------------------------------------------------------
    // Output decode from the state being entered
    // ---------------------------------------------------------------------
    always_comb begin
        lf_clear_nxt = (state_nxt == ST_CLEAR);
        nco_hold_nxt = !loop_running(state_nxt);
        locked_nxt   = (state_nxt == ST_TRACK);
        loss_nxt     = (state == ST_TRACK) &&
                       (state_nxt == ST_ACQUIRE || state_nxt == ST_HOLDOVER);

        kp_nxt = KP_ACQ_V;
        ki_nxt = KI_ACQ_V;
        case (state_nxt)
            ST_TRACK: begin
                kp_nxt = KP_TRK_V;
                ki_nxt = KI_TRK_V;
            end
            // Holdover keeps whatever gains the loop was running with.
            ST_HOLDOVER: begin
                kp_nxt = kp_sh;
                ki_nxt = ki_sh;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // State, counter and output registers
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            win_cnt    <= '0;
            miss_cnt   <= '0;
            clr_cnt    <= '0;
            wdog_cnt   <= '0;
            lf_clear   <= 1'b0;
            nco_hold   <= 1'b1;
            kp_sh      <= KP_ACQ_V;
            ki_sh      <= KI_ACQ_V;
            locked     <= 1'b0;
            loss_pulse <= 1'b0;
        end else if (ena) begin
            state      <= state_nxt;
            win_cnt    <= win_nxt;
            miss_cnt   <= miss_nxt;
            clr_cnt    <= clr_nxt;
            wdog_cnt   <= wdog_nxt;
            lf_clear   <= lf_clear_nxt;
            nco_hold   <= nco_hold_nxt;
            kp_sh      <= kp_nxt;
            ki_sh      <= ki_nxt;
            locked     <= locked_nxt;
            loss_pulse <= loss_nxt;
        end else begin
            // Frozen, but a pulse must not be stretched across the freeze.
            loss_pulse <= 1'b0;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_ddmtd_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ddmtd_lock_ctrl
//   Self-checking bench for ddmtd_lock_ctrl (WDOG_W = 6, other defaults).
//   A behavioural model built from the sequencing rules is stepped on every
//   rising edge with the same inputs the DUT sees; directed scenarios check
//   against fixed expected values, the random scenario against the model.
// -----------------------------------------------------------------------------
module tb_ddmtd_lock_ctrl;

    localparam int ERR_W      = 18;
    localparam int SH_W       = 4;
    localparam int LOCK_THR   = 64;
    localparam int LOCK_CNT   = 16;
    localparam int UNLOCK_CNT = 4;
    localparam int CLEAR_CYC  = 4;
    localparam int WDOG_W     = 6;
    localparam int WDOG_TERM  = (1 << WDOG_W) - 1;

    localparam int S_IDLE = 0, S_CLEAR = 1, S_ACQ = 2, S_TRACK = 3, S_HOLD = 4;

    logic             clk;
    logic             rst_n;
    logic             ena;
    logic             loop_en;
    logic             phase_valid;
    logic [ERR_W-1:0] phase_err;
    logic             lf_clear;
    logic             nco_hold;
    logic [SH_W-1:0]  kp_sh;
    logic [SH_W-1:0]  ki_sh;
    logic             locked;
    logic             loss_pulse;
    logic [2:0]       state_o;

    int checks = 0;
    int errors = 0;

    ddmtd_lock_ctrl #(
        .ERR_W  (ERR_W),
        .WDOG_W (WDOG_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .loop_en     (loop_en),
        .phase_valid (phase_valid),
        .phase_err   (phase_err),
        .lf_clear    (lf_clear),
        .nco_hold    (nco_hold),
        .kp_sh       (kp_sh),
        .ki_sh       (ki_sh),
        .locked      (locked),
        .loss_pulse  (loss_pulse),
        .state_o     (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int m_state, m_clr, m_run, m_miss, m_idle, m_kp, m_ki;
    bit m_loss;

    function automatic bit in_window(input logic [ERR_W-1:0] e);
        int v;
        v = int'($signed(e));
        if (v == -(1 << (ERR_W - 1))) return 1'b0;
        if (v < 0) v = -v;
        return v <= LOCK_THR;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE;
        m_clr = 0; m_run = 0; m_miss = 0; m_idle = 0;
        m_kp = 2; m_ki = 8;
        m_loss = 1'b0;
    endtask

    task automatic model_step();
        int nxt;
        bit w;
        if (!ena) begin
            m_loss = 1'b0;
            return;
        end
        nxt = m_state;
        w   = in_window(phase_err);
        if (!loop_en) nxt = S_IDLE;
        else begin
            case (m_state)
                S_IDLE:  nxt = S_CLEAR;
                S_CLEAR: begin
                    m_clr++;
                    if (m_clr == CLEAR_CYC) nxt = S_ACQ;
                end
                S_ACQ: begin
                    if (phase_valid) begin
                        m_idle = 0;
                        m_run  = w ? m_run + 1 : 0;
                        if (m_run == LOCK_CNT) nxt = S_TRACK;
                    end else begin
                        m_idle++;
                        if (m_idle == WDOG_TERM) nxt = S_HOLD;
                    end
                end
                S_TRACK: begin
                    if (phase_valid) begin
                        m_idle = 0;
                        m_miss = w ? 0 : m_miss + 1;
                        if (m_miss == UNLOCK_CNT) nxt = S_ACQ;
                    end else begin
                        m_idle++;
                        if (m_idle == WDOG_TERM) nxt = S_HOLD;
                    end
                end
                default: if (phase_valid) nxt = S_CLEAR;
            endcase
        end
        m_loss = (m_state == S_TRACK) && (nxt == S_ACQ || nxt == S_HOLD);
        if (nxt != m_state) begin
            m_clr = 0; m_run = 0; m_miss = 0; m_idle = 0;
        end
        if (nxt == S_TRACK) begin
            m_kp = 4; m_ki = 10;
        end else if (nxt != S_HOLD) begin
            m_kp = 2; m_ki = 8;
        end
        m_state = nxt;
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking here)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic send(input int err);
        phase_valid = 1'b1;
        phase_err   = ERR_W'(err);
        tick();
        phase_valid = 1'b0;
    endtask

    function automatic int rand_in_win();
        if ($urandom_range(0, 1) == 0) return ($urandom_range(0, 1) == 0) ? 64 : -64;
        return int'($urandom_range(0, 128)) - 64;
    endfunction

    task automatic drive_to_track();
        loop_en = 1'b1;
        ena     = 1'b1;
        for (int i = 0; i < 40 && m_state != S_ACQ && m_state != S_TRACK; i++) begin
            if (m_state == S_HOLD) send(0);
            else tick();
        end
        for (int i = 0; i < LOCK_CNT + 4 && m_state == S_ACQ; i++) send(rand_in_win());
        checks++;
        if (state_o !== 3'd3) begin
            errors++;
            $display("FAIL drive_to_track: state_o=%0d expected 3", state_o);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b0; loop_en = 1'b0; phase_valid = 1'b0; phase_err = '0;
        model_reset();
        #12;
        checks++;
        if ({state_o, lf_clear, nco_hold, kp_sh, ki_sh, locked, loss_pulse} !==
            {3'd0, 1'b0, 1'b1, 4'd2, 4'd8, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: state=%0d lfc=%0b hold=%0b kp=%0d ki=%0d lock=%0b loss=%0b expected 0 0 1 2 8 0 0",
                     state_o, lf_clear, nco_hold, kp_sh, ki_sh, locked, loss_pulse);
        end
        #1 rst_n = 1'b1;
        tick();
    endtask

    // Enabling the loop: one CLEAR dwell of exactly CLEAR_CYC cycles. In-window
    // samples are offered throughout CLEAR; they must not count towards lock.
    task automatic test_clear();
        int n_clr = 0;
        bit first_ok;
        ena = 1'b1; loop_en = 1'b1;
        phase_valid = 1'b1; phase_err = ERR_W'(5);
        tick();
        first_ok = (state_o == 3'd1);
        if (lf_clear === 1'b1) n_clr++;
        for (int i = 0; i < 10 && state_o !== 3'd2; i++) begin
            tick();
            if (lf_clear === 1'b1) n_clr++;
        end
        phase_valid = 1'b0;
        checks++;
        if (!first_ok) begin
            errors++;
            $display("FAIL clear_entry: state_o did not become 1 one cycle after loop_en");
        end
        checks++;
        if (n_clr != CLEAR_CYC) begin
            errors++;
            $display("FAIL clear_len: lf_clear high %0d cycles expected %0d", n_clr, CLEAR_CYC);
        end
        checks++;
        if ({state_o, lf_clear, nco_hold, kp_sh, ki_sh} !== {3'd2, 1'b0, 1'b0, 4'd2, 4'd8}) begin
            errors++;
            $display("FAIL acquire_entry: state=%0d lfc=%0b hold=%0b kp=%0d ki=%0d expected 2 0 0 2 8",
                     state_o, lf_clear, nco_hold, kp_sh, ki_sh);
        end
    endtask

    task automatic test_acquire();
        for (int i = 0; i < LOCK_CNT - 1; i++) begin
            send(rand_in_win());
            repeat ($urandom_range(0, 2)) tick();
        end
        send(65);
        checks++;
        if ({state_o, locked} !== {3'd2, 1'b0}) begin
            errors++;
            $display("FAIL no_lock_after_65: state=%0d locked=%0b expected 2 0", state_o, locked);
        end
        for (int i = 0; i < LOCK_CNT - 1; i++) send(rand_in_win());
        checks++;
        if (state_o !== 3'd2) begin
            errors++;
            $display("FAIL win_restart: state=%0d after 15 samples expected 2", state_o);
        end
        send(-64);
        checks++;
        if ({state_o, locked, nco_hold, kp_sh, ki_sh} !== {3'd3, 1'b1, 1'b0, 4'd4, 4'd10}) begin
            errors++;
            $display("FAIL lock: state=%0d locked=%0b hold=%0b kp=%0d ki=%0d expected 3 1 0 4 10",
                     state_o, locked, nco_hold, kp_sh, ki_sh);
        end
    endtask

    task automatic test_track_unlock();
        int bad = 0;
        for (int i = 0; i < 3; i++) begin
            send(1000);
            if ({state_o, locked} !== {3'd3, 1'b1}) bad++;
        end
        send(0);
        if ({state_o, locked} !== {3'd3, 1'b1}) bad++;
        for (int i = 0; i < 3; i++) begin
            send(-1000);
            if ({state_o, locked, loss_pulse} !== {3'd3, 1'b1, 1'b0}) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL track_hold: %0d cycles left lock early, expected 0", bad);
        end
        send(-1000);
        checks++;
        if ({state_o, locked, loss_pulse, kp_sh, ki_sh} !== {3'd2, 1'b0, 1'b1, 4'd2, 4'd8}) begin
            errors++;
            $display("FAIL unlock: state=%0d locked=%0b loss=%0b kp=%0d ki=%0d expected 2 0 1 2 8",
                     state_o, locked, loss_pulse, kp_sh, ki_sh);
        end
        tick();
        checks++;
        if (loss_pulse !== 1'b0) begin
            errors++;
            $display("FAIL loss_width: loss_pulse=%0b on second cycle expected 0", loss_pulse);
        end
    endtask

    task automatic test_watchdog();
        drive_to_track();
        repeat (WDOG_TERM - 1) tick();
        checks++;
        if (state_o !== 3'd3) begin
            errors++;
            $display("FAIL wdog_early: state=%0d after %0d idle cycles expected 3", state_o, WDOG_TERM - 1);
        end
        tick();
        checks++;
        if ({state_o, nco_hold, locked, loss_pulse, kp_sh, ki_sh} !== {3'd4, 1'b1, 1'b0, 1'b1, 4'd4, 4'd10}) begin
            errors++;
            $display("FAIL holdover: state=%0d hold=%0b locked=%0b loss=%0b kp=%0d ki=%0d expected 4 1 0 1 4 10",
                     state_o, nco_hold, locked, loss_pulse, kp_sh, ki_sh);
        end
        tick();
        checks++;
        if ({state_o, loss_pulse, lf_clear} !== {3'd4, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL holdover_stay: state=%0d loss=%0b lfc=%0b expected 4 0 0", state_o, loss_pulse, lf_clear);
        end
        send(100000);
        checks++;
        if ({state_o, lf_clear} !== {3'd1, 1'b1}) begin
            errors++;
            $display("FAIL holdover_exit: state=%0d lfc=%0b expected 1 1", state_o, lf_clear);
        end
    endtask

    task automatic test_wdog_race();
        drive_to_track();
        repeat (WDOG_TERM - 1) tick();
        send(-131072);
        checks++;
        if ({state_o, locked, nco_hold} !== {3'd3, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wdog_race: state=%0d locked=%0b hold=%0b expected 3 1 0", state_o, locked, nco_hold);
        end
        for (int i = 0; i < UNLOCK_CNT - 1; i++) send(-131072);
        checks++;
        if ({state_o, loss_pulse} !== {3'd2, 1'b1}) begin
            errors++;
            $display("FAIL most_neg_out_of_win: state=%0d loss=%0b expected 2 1", state_o, loss_pulse);
        end
    endtask

    task automatic test_ena_freeze();
        int moved = 0;
        for (int i = 0; i < 10; i++) send(rand_in_win());
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send(rand_in_win());
            if ({state_o, locked, nco_hold} !== {3'd2, 1'b0, 1'b0}) moved++;
        end
        ena = 1'b1;
        checks++;
        if (moved != 0) begin
            errors++;
            $display("FAIL ena_freeze: outputs moved on %0d frozen cycles expected 0", moved);
        end
        for (int i = 0; i < 5; i++) send(rand_in_win());
        checks++;
        if (state_o !== 3'd2) begin
            errors++;
            $display("FAIL ena_counter_hold: state=%0d after 15 counted samples expected 2", state_o);
        end
        send(rand_in_win());
        checks++;
        if (state_o !== 3'd3) begin
            errors++;
            $display("FAIL ena_resume_lock: state=%0d after 16 counted samples expected 3", state_o);
        end
        loop_en = 1'b0;
        tick();
        checks++;
        if ({state_o, nco_hold, locked, kp_sh, ki_sh} !== {3'd0, 1'b1, 1'b0, 4'd2, 4'd8}) begin
            errors++;
            $display("FAIL loop_disable: state=%0d hold=%0b locked=%0b kp=%0d ki=%0d expected 0 1 0 2 8",
                     state_o, nco_hold, locked, kp_sh, ki_sh);
        end
        loop_en = 1'b1;
    endtask

    // Long random run against the model. Error quality alternates between
    // a clean and a noisy regime so that both lock and unlock occur, with
    // occasional sample droughts to exercise the watchdog.
    task automatic test_random();
        int silence = 0;
        bit good    = 1'b1;
        int bad     = 0;
        logic [14:0] got, exp;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 199) == 0) good = !good;
            loop_en = ($urandom_range(0, 499) != 0);
            ena     = ($urandom_range(0, 19) != 0);
            if (silence > 0) begin
                silence--;
                phase_valid = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                silence     = int'($urandom_range(50, 90));
                phase_valid = 1'b0;
            end else begin
                phase_valid = ($urandom_range(0, 2) == 0);
            end
            if ($urandom_range(0, 99) < (good ? 96 : 40)) begin
                phase_err = ERR_W'(rand_in_win());
            end else begin
                case ($urandom_range(0, 3))
                    0: phase_err = ERR_W'(65);
                    1: phase_err = ERR_W'(-65);
                    2: phase_err = {1'b1, {(ERR_W-1){1'b0}}};
                    default: phase_err = ERR_W'($urandom);
                endcase
            end
            tick();
            got = {state_o, lf_clear, nco_hold, kp_sh, ki_sh, locked, loss_pulse};
            exp = {3'(m_state), m_state == S_CLEAR, !(m_state == S_ACQ || m_state == S_TRACK),
                   4'(m_kp), 4'(m_ki), m_state == S_TRACK, m_loss};
            checks++;
            if (got !== exp) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_vs_model cycle %0d: got %h expected %h", cyc, got, exp);
            end
        end
        phase_valid = 1'b0;
        ena = 1'b1;
        loop_en = 1'b1;
    endtask

    task automatic test_async_reset();
        drive_to_track();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({state_o, lf_clear, nco_hold, kp_sh, ki_sh, locked, loss_pulse} !==
            {3'd0, 1'b0, 1'b1, 4'd2, 4'd8, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: state=%0d lfc=%0b hold=%0b kp=%0d ki=%0d lock=%0b loss=%0b expected 0 0 1 2 8 0 0",
                     state_o, lf_clear, nco_hold, kp_sh, ki_sh, locked, loss_pulse);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clear();
        test_acquire();
        test_track_unlock();
        test_watchdog();
        test_wdog_race();
        test_ena_freeze();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
